mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory.
// One transaction is in flight at a time. Data requests are favoured, but an
// instruction request is never starved for more than MAX_STREAK data grants.
module mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  streak;
    logic [1:0]  wait_cnt;
    logic        win_i;     // 1 = current transaction belongs to the fetch port

    // Data wins unless the fetch port has already waited out MAX_STREAK data grants.
    logic grant_d;
    always_comb begin
        grant_d = d_req && !(i_req && (streak == 3'(MAX_STREAK)));
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= 3'd0;
            wait_cnt  <= 2'd0;
            win_i     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    i_valid <= 1'b0;
                    d_valid <= 1'b0;
                    if (grant_d) begin
                        win_i     <= 1'b0;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        streak    <= i_req ? streak + 3'd1 : 3'd0;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end else if (i_req) begin
                        win_i     <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        streak    <= 3'd0;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        // Stores complete without waiting for the memory.
                        i_valid <= win_i;
                        d_valid <= !win_i;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= 2'd0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'(MEM_LAT - 1)) begin
                        // mem_rdata is valid in this final WAIT cycle.
                        if (win_i) begin
                            i_rdata <= mem_rdata;
                        end else begin
                            d_rdata <= mem_rdata;
                        end
                        i_valid <= win_i;
                        d_valid <= !win_i;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RESP: begin
                    i_valid <= 1'b0;
                    d_valid <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
